// File: rtl/prog_timer.sv
// Programmable interval timer.
// Counts prescaled ticks from 0 up to a latched period and emits a one-cycle
// trigger pulse on the terminal tick. Supports periodic (auto-reload) and
// one-shot operation, plus pause (enable low), restart (start) and abort (stop).
module prog_timer #(
    parameter int WIDTH      = 7,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      period,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  trigger,
    output logic [WIDTH-1:0]      timeRemaining,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [WIDTH-1:0]        count;
    logic [WIDTH-1:0]        period_q;
    logic [PRESCALE_W-1:0]   prescaler;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic                    mode_q;

    logic                    tick;
    logic                    terminal;

    // A tick is one enabled clock in every prescale_q+1; the terminal tick
    // is the one that finds the counter already at the latched period.
    assign tick     = (state == RUN) && enable && (prescaler == prescale_q);
    assign terminal = tick && (count == period_q);

    // Control FSM, counter, prescaler and latched configuration in one
    // registered block; priority is reset > start > stop > counting.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            prescaler  <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            mode_q     <= 1'b0;
            trigger    <= 1'b0;
        end else if (start) begin
            state      <= RUN;
            count      <= '0;
            prescaler  <= '0;
            period_q   <= period;
            prescale_q <= prescale;
            mode_q     <= mode;
            trigger    <= 1'b0;
        end else if (stop) begin
            state     <= IDLE;
            count     <= '0;
            prescaler <= '0;
            trigger   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!enable) begin
                        // Paused: counter and prescaler hold.
                        trigger <= 1'b0;
                    end else if (!tick) begin
                        prescaler <= prescaler + 1'b1;
                        trigger   <= 1'b0;
                    end else if (terminal) begin
                        prescaler <= '0;
                        count     <= '0;
                        trigger   <= 1'b1;
                        if (mode_q) begin
                            state <= DONE;
                        end else begin
                            // Periodic wrap picks up the live period/prescale.
                            period_q   <= period;
                            prescale_q <= prescale;
                        end
                    end else begin
                        prescaler <= '0;
                        count     <= count + 1'b1;
                        trigger   <= 1'b0;
                    end
                end
                DONE: begin
                    count     <= '0;
                    prescaler <= '0;
                    trigger   <= 1'b0;
                end
                IDLE: begin
                    trigger <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    count   <= '0;
                    trigger <= 1'b0;
                end
            endcase
        end
    end

    // Status decoded directly from the state and counter registers.
    assign timeRemaining = (state == RUN) ? (period_q - count) : '0;
    assign busy          = (state == RUN);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: directed scenarios plus a long
// randomized run, every cycle compared against an elapsed-time model.
module tb_prog_timer;

    localparam int WIDTH      = 7;
    localparam int PRESCALE_W = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  stop;
    logic                  enable;
    logic                  mode;
    logic [WIDTH-1:0]      period;
    logic [PRESCALE_W-1:0] prescale;
    logic                  trigger;
    logic [WIDTH-1:0]      timeRemaining;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;

    // Reference model: state plus the number of enabled clocks elapsed in
    // the current interval. An interval lasts (P+1)*(D+1) enabled clocks and
    // the tick count so far is elapsed/(D+1).
    int m_state = 0;  // 0 idle, 1 run, 2 done
    int m_p     = 0;
    int m_d     = 0;
    int m_mode  = 0;
    int m_el    = 0;
    int m_trig  = 0;

    prog_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .enable       (enable),
        .mode         (mode),
        .period       (period),
        .prescale     (prescale),
        .trigger      (trigger),
        .timeRemaining(timeRemaining),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step();
        if (reset) begin
            m_state = 0; m_p = 0; m_d = 0; m_mode = 0; m_el = 0; m_trig = 0;
        end else if (start) begin
            m_state = 1; m_p = int'(period); m_d = int'(prescale);
            m_mode = int'(mode); m_el = 0; m_trig = 0;
        end else if (stop) begin
            m_state = 0; m_el = 0; m_trig = 0;
        end else if (m_state == 1) begin
            m_trig = 0;
            if (enable) begin
                m_el++;
                if (m_el == (m_p + 1) * (m_d + 1)) begin
                    m_trig = 1;
                    m_el   = 0;
                    if (m_mode != 0) begin
                        m_state = 2;
                    end else begin
                        m_p = int'(period);
                        m_d = int'(prescale);
                    end
                end
            end
        end else begin
            m_trig = 0;
        end
    endfunction

    // One clock: model follows the edge, outputs compared 1 time unit later,
    // then the one-cycle pulses are released.
    task automatic tick();
        int exp_rem;
        @(posedge clock);
        model_step();
        #1;
        exp_rem = (m_state == 1) ? (m_p - m_el / (m_d + 1)) : 0;
        check("model_trigger", int'(trigger), m_trig);
        check("model_busy", int'(busy), (m_state == 1) ? 1 : 0);
        check("model_done", int'(done), (m_state == 2) ? 1 : 0);
        check("model_time_remaining", int'(timeRemaining), exp_rem);
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic go(input int p, input int d, input int md);
        period   = WIDTH'(p);
        prescale = PRESCALE_W'(d);
        mode     = md[0];
        enable   = 1'b1;
        start    = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b0;
        mode = 1'b0; period = '0; prescale = '0;
        @(negedge clock);
        tick();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_trigger", int'(trigger), 0);
        check("reset_time_remaining", int'(timeRemaining), 0);

        // Reset mid-run at count 5.
        go(10, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        check("pre_reset_rem", int'(timeRemaining), 5);
        reset = 1'b1;
        tick();
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_rem", int'(timeRemaining), 0);
        check("midrun_reset_trig", int'(trigger), 0);

        // Periodic P=5, D=0: triggers after edges k+6, k+12, k+18.
        go(5, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("periodic_trig", int'(trigger), (i % 6 == 0) ? 1 : 0);
            check("periodic_rem", int'(timeRemaining), 5 - (i % 6));
        end

        // One-shot P=3, D=2: single trigger 12 clocks after start.
        go(3, 2, 1);
        for (int i = 1; i <= 62; i++) begin
            tick();
            check("oneshot_trig", int'(trigger), (i == 12) ? 1 : 0);
            if (i >= 12) begin
                check("oneshot_done", int'(done), 1);
                check("oneshot_busy", int'(busy), 0);
            end
        end

        // Pause for 4 cycles at count 4: trigger moves from 10 to 14.
        go(9, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            enable = (i >= 5 && i <= 8) ? 1'b0 : 1'b1;
            tick();
            check("pause_trig", int'(trigger), (i == 14) ? 1 : 0);
            if (i >= 4 && i <= 8) check("pause_hold_rem", int'(timeRemaining), 5);
        end

        // Restart at count 7: trigger 10 cycles after the second start.
        go(9, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        start = 1'b1;
        tick();
        check("restart_rem", int'(timeRemaining), 9);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("restart_trig", int'(trigger), (i == 10) ? 1 : 0);
        end

        // P=0, D=0 periodic: trigger every cycle.
        go(0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("p0_trig", int'(trigger), 1);
        end

        // P=127: trigger every 128 cycles.
        go(127, 0, 0);
        for (int i = 1; i <= 260; i++) begin
            tick();
            check("p127_trig", int'(trigger), (i % 128 == 0) ? 1 : 0);
        end

        // start and stop on the same edge enter RUN.
        stop = 1'b1;
        tick();
        check("stop_idle_busy", int'(busy), 0);
        period = 7'd6; start = 1'b1; stop = 1'b1;
        tick();
        check("start_stop_busy", int'(busy), 1);

        // Live reload: interval of 5, then intervals of 3.
        go(4, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            if (i == 2) period = 7'd2;
            tick();
            check("reload_trig", int'(trigger),
                  (i == 5 || i == 8 || i == 11 || i == 14) ? 1 : 0);
        end

        // Randomized run against the model.
        for (int n = 0; n < 15000; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) begin
                period   = ($urandom_range(0, 15) == 0) ? 7'd127 : WIDTH'($urandom_range(0, 12));
                prescale = PRESCALE_W'($urandom_range(0, 3));
                mode     = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 24) == 0) start = 1'b1;
            if ($urandom_range(0, 79) == 0) stop  = 1'b1;
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
